jump_resolver: RTL and testbench
================================

JUMP_RESOLVER -- requirements
Module: jump_resolver

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the ALU result width sampled for flag generation.
REQ-002 SHALL have parameter NUM_LOOP, default 4, meaning the number of loop counters (power of two, at least 2).
REQ-003 SHALL have parameter LOOP_W, default 16, meaning the width of each loop counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  clock; i_rst  in  1  synchronous active-high reset.
REQ-005 SHALL have i_flag_we  in  1  flag update strobe from ALU writeback.
REQ-006 SHALL have i_result  in  DATA_W  ALU result.
REQ-007 SHALL have i_carry  in  1  ALU carry-out.
REQ-008 SHALL have i_overflow  in  1  ALU signed overflow.
REQ-009 SHALL have i_req_valid  in  1  jump request valid.
REQ-010 SHALL have o_req_ready  out  1  request accepted when high with i_req_valid.
REQ-011 SHALL have i_cond  in  4  condition code.
REQ-012 SHALL have i_loop_sel  in  log2(NUM_LOOP)  loop counter used by DJNZ.
REQ-013 SHALL have i_loop_load  in  1  load strobe for the counter selected by i_loop_sel.
REQ-014 SHALL have i_loop_val  in  LOOP_W  load value.
REQ-015 SHALL have o_resp_valid  out  1  decision valid.
REQ-016 SHALL have i_resp_ready  in  1  consumer accepts the decision.
REQ-017 SHALL have o_taken  out  1  jump taken.
REQ-018 SHALL have o_flags  out  4  registered {S,Z,C,V}.

Function
REQ-019 SHALL update the flag register on i_flag_we as follows: S = i_result MSB; Z = (i_result == 0); C = i_carry; V = i_overflow. Flags SHALL hold when i_flag_we is low.
REQ-020 SHALL decode condition codes 0..15 as: ALWAYS, NEVER, Z, NZ, S, NS, C, NC, V, NV, LT (S^V), GE (~(S^V)), ULE (~C|Z), UGT (C&~Z), DJNZ, RSVD (not taken).
REQ-021 SHALL bypass flags: when a request is accepted in the same cycle as i_flag_we, the decision SHALL use the newly computed flags.
REQ-022 SHALL accept a request when i_req_valid & o_req_ready; o_req_ready = ~o_resp_valid | i_resp_ready.
REQ-023 SHALL register the decision with exactly 1-cycle latency: o_resp_valid and o_taken SHALL be valid the cycle after acceptance.
REQ-024 SHALL hold o_resp_valid and o_taken stable while o_resp_valid & ~i_resp_ready.
REQ-025 SHALL clear o_resp_valid after a handshake if no new request was accepted in the same cycle; back-to-back requests SHALL give one decision per cycle.
REQ-026 SHALL, for DJNZ on acceptance, write counter[i_loop_sel] - 1 (mod 2^LOOP_W) and decide taken iff that decremented value is nonzero.
REQ-027 SHALL wrap a DJNZ on a counter of 0 to all-ones and report it as taken.
REQ-028 SHALL give i_loop_load priority over a simultaneous DJNZ on the same counter: the counter takes i_loop_val, and the decision uses the old value minus 1.
REQ-029 SHALL let i_loop_load act independently of request flow control.
REQ-030 SHALL make o_flags reflect the registered flags, not bypassed ones.

Reset
REQ-031 SHALL, on i_rst, clear flags to 0, all loop counters to 0, o_resp_valid to 0 and o_taken to 0.
REQ-032 SHALL discard any pending decision when i_rst asserts mid-operation and ignore requests, loads and flag writes during that cycle.
REQ-033 SHALL drive o_req_ready high in the first cycle after reset.

Structure
REQ-034 SHALL define condition-code constants (COND_ALWAYS..COND_RSVD) and flag bit indices (FLAG_S, FLAG_Z, FLAG_C, FLAG_V) in a shared package jump_pkg.
REQ-035 SHALL place the combinational flags-plus-code-to-taken evaluation in one sub-module, cond_eval; loop counters, bypass and the output register SHALL stay in jump_resolver.

Verification
REQ-036 SHALL cover: flag write i_result=0x0000, i_carry=0 -> o_flags={0,1,0,0}, then COND Z gives o_taken=1 one cycle later and NZ gives 0.
REQ-037 SHALL cover: same-cycle i_flag_we (i_result=0x8000) and request LT with i_overflow=0 -> o_taken=1 (bypass).
REQ-038 SHALL cover: load counter 1 with 3, then three DJNZ on counter 1 -> taken, taken, not taken; a fourth DJNZ -> taken with counter at 0xFFFF.
REQ-039 SHALL cover: i_resp_ready low for 3 cycles with a pending decision -> o_resp_valid and o_taken held, o_req_ready=0; release -> next request accepted that cycle.
REQ-040 SHALL cover: i_rst asserted with o_resp_valid=1 -> next cycle o_resp_valid=0, o_flags=0, counters 0.
REQ-041 SHALL cover: same-cycle load of 5 and DJNZ on a counter holding 1 -> o_taken=0 and counter=5.

Source files
------------

// File: rtl/jump_pkg.sv
// jump_pkg: condition codes and flag bit positions shared by the jump resolver
package jump_pkg;
  typedef enum logic [3:0] {
    COND_ALWAYS = 4'd0,
    COND_NEVER  = 4'd1,
    COND_Z      = 4'd2,
    COND_NZ     = 4'd3,
    COND_S      = 4'd4,
    COND_NS     = 4'd5,
    COND_C      = 4'd6,
    COND_NC     = 4'd7,
    COND_V      = 4'd8,
    COND_NV     = 4'd9,
    COND_LT     = 4'd10,
    COND_GE     = 4'd11,
    COND_ULE    = 4'd12,
    COND_UGT    = 4'd13,
    COND_DJNZ   = 4'd14,
    COND_RSVD   = 4'd15
  } cond_e;
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: maps {S,Z,C,V} flags and a condition code to a taken decision
module cond_eval
  import jump_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  input  logic       i_djnz_nz,
  output logic       o_taken
);
  logic s, z, c, v;
  always_comb begin
    s = i_flags[FLAG_S];
    z = i_flags[FLAG_Z];
    c = i_flags[FLAG_C];
    v = i_flags[FLAG_V];
    o_taken = 1'b0;
    case (cond_e'(i_cond))
      COND_ALWAYS: o_taken = 1'b1;
      COND_NEVER:  o_taken = 1'b0;
      COND_Z:      o_taken = z;
      COND_NZ:     o_taken = ~z;
      COND_S:      o_taken = s;
      COND_NS:     o_taken = ~s;
      COND_C:      o_taken = c;
      COND_NC:     o_taken = ~c;
      COND_V:      o_taken = v;
      COND_NV:     o_taken = ~v;
      COND_LT:     o_taken = s ^ v;
      COND_GE:     o_taken = ~(s ^ v);
      COND_ULE:    o_taken = ~c | z;
      COND_UGT:    o_taken = c & ~z;
      COND_DJNZ:   o_taken = i_djnz_nz;
      default:     o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/jump_resolver.sv
// jump_resolver: ALU flag register, loop counters and a registered jump decision
module jump_resolver
  import jump_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_LOOP = 4,
  parameter int LOOP_W   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flag_we,
  input  logic [DATA_W-1:0]           i_result,
  input  logic                        i_carry,
  input  logic                        i_overflow,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic [3:0]                  i_cond,
  input  logic [$clog2(NUM_LOOP)-1:0] i_loop_sel,
  input  logic                        i_loop_load,
  input  logic [LOOP_W-1:0]           i_loop_val,
  output logic                        o_resp_valid,
  input  logic                        i_resp_ready,
  output logic                        o_taken,
  output logic [3:0]                  o_flags
);
  localparam int SEL_W = $clog2(NUM_LOOP);
  logic [3:0]        flags_q, flags_d, new_flags;
  logic [LOOP_W-1:0] cnt_q [NUM_LOOP];
  logic [LOOP_W-1:0] cnt_d [NUM_LOOP];
  logic [LOOP_W-1:0] cnt_dec;
  logic              resp_valid_q, resp_valid_d, taken_q, taken_d;
  logic              accept, djnz, taken_c;
  cond_eval u_cond_eval (
    .i_flags   (flags_d),
    .i_cond    (i_cond),
    .i_djnz_nz (|cnt_dec),
    .o_taken   (taken_c)
  );
  // flags_d doubles as the bypass path: a same-cycle flag write is seen by the decision
  always_comb begin
    new_flags = {i_result[DATA_W-1], ~|i_result, i_carry, i_overflow};
    flags_d = i_flag_we ? new_flags : flags_q;
    o_req_ready = ~resp_valid_q | i_resp_ready;
    accept = i_req_valid & o_req_ready;
    djnz = accept & (i_cond == COND_DJNZ);
    cnt_dec = cnt_q[i_loop_sel] - LOOP_W'(1);
    for (int k = 0; k < NUM_LOOP; k++)
      cnt_d[k] = (i_loop_load && i_loop_sel == SEL_W'(k)) ? i_loop_val :
                 (djnz && i_loop_sel == SEL_W'(k)) ? cnt_dec : cnt_q[k];
    resp_valid_d = accept | (resp_valid_q & ~i_resp_ready);
    taken_d = accept ? taken_c : taken_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flags_q <= '0;
      resp_valid_q <= 1'b0;
      taken_q <= 1'b0;
      for (int k = 0; k < NUM_LOOP; k++) cnt_q[k] <= '0;
    end else begin
      flags_q <= flags_d;
      resp_valid_q <= resp_valid_d;
      taken_q <= taken_d;
      for (int k = 0; k < NUM_LOOP; k++) cnt_q[k] <= cnt_d[k];
    end
  end
  assign o_resp_valid = resp_valid_q;
  assign o_taken = taken_q;
  assign o_flags = flags_q;
endmodule

// File: tb/tb_jump_resolver.sv
// tb_jump_resolver: directed checks of flags, bypass, DJNZ, backpressure and reset
module tb_jump_resolver;
  logic        clk = 1'b0;
  logic        rst, flag_we, carry, overflow, req_valid, req_ready;
  logic [15:0] result, loop_val;
  logic [3:0]  cond, flags;
  logic [1:0]  loop_sel;
  logic        loop_load, resp_valid, resp_ready, taken;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  jump_resolver dut (
    .i_clk(clk), .i_rst(rst), .i_flag_we(flag_we), .i_result(result),
    .i_carry(carry), .i_overflow(overflow), .i_req_valid(req_valid),
    .o_req_ready(req_ready), .i_cond(cond), .i_loop_sel(loop_sel),
    .i_loop_load(loop_load), .i_loop_val(loop_val), .o_resp_valid(resp_valid),
    .i_resp_ready(resp_ready), .o_taken(taken), .o_flags(flags)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; flag_we = 0; result = 0; carry = 0; overflow = 0; req_valid = 0;
    cond = 0; loop_sel = 0; loop_load = 0; loop_val = 0; resp_ready = 1;
    step(); step();
    rst = 0;
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_taken", 32'(taken), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_ready", 32'(req_ready), 1);
    // zero result sets Z only
    flag_we = 1; result = 16'h0000; carry = 0; overflow = 0;
    step();
    flag_we = 0; result = 16'h1234; carry = 1;
    chk("flags_zero", 32'(flags), 32'b0100);
    req_valid = 1; cond = 4'd2;
    step();
    chk("z_valid", 32'(resp_valid), 1);
    chk("z_taken", 32'(taken), 1);
    chk("flags_hold", 32'(flags), 32'b0100);
    cond = 4'd3;
    step();
    chk("nz_taken", 32'(taken), 0);
    chk("nz_valid", 32'(resp_valid), 1);
    req_valid = 0;
    step();
    chk("idle_valid", 32'(resp_valid), 0);
    // bypass: S=1, V=0 written with the LT request
    flag_we = 1; result = 16'h8000; carry = 0; overflow = 0; req_valid = 1; cond = 4'd10;
    step();
    flag_we = 0;
    chk("lt_bypass", 32'(taken), 1);
    chk("flags_s", 32'(flags), 32'b1000);
    cond = 4'd11; step(); chk("ge", 32'(taken), 0);
    cond = 4'd12; step(); chk("ule", 32'(taken), 1);
    cond = 4'd13; step(); chk("ugt", 32'(taken), 0);
    flag_we = 1; result = 16'h0001; carry = 1; overflow = 1; cond = 4'd6;
    step();
    flag_we = 0;
    chk("flags_cv", 32'(flags), 32'b0011);
    chk("c_bypass", 32'(taken), 1);
    cond = 4'd9;  step(); chk("nv", 32'(taken), 0);
    cond = 4'd8;  step(); chk("v", 32'(taken), 1);
    cond = 4'd15; step(); chk("rsvd", 32'(taken), 0);
    cond = 4'd0;  step(); chk("always", 32'(taken), 1);
    cond = 4'd1;  step(); chk("never", 32'(taken), 0);
    req_valid = 0;
    // DJNZ sequence on counter 1
    loop_load = 1; loop_sel = 1; loop_val = 16'd3;
    step();
    loop_load = 0;
    chk("load_cnt1", 32'(dut.cnt_q[1]), 3);
    req_valid = 1; cond = 4'd14;
    step(); chk("djnz1", 32'(taken), 1); chk("cnt_2", 32'(dut.cnt_q[1]), 2);
    step(); chk("djnz2", 32'(taken), 1); chk("cnt_1", 32'(dut.cnt_q[1]), 1);
    step(); chk("djnz3", 32'(taken), 0); chk("cnt_0", 32'(dut.cnt_q[1]), 0);
    step(); chk("djnz_wrap", 32'(taken), 1); chk("cnt_ffff", 32'(dut.cnt_q[1]), 32'hFFFF);
    chk("cnt0_untouched", 32'(dut.cnt_q[0]), 0);
    // backpressure
    cond = 4'd0; resp_ready = 0;
    step();
    chk("bp_valid0", 32'(resp_valid), 1);
    chk("bp_taken0", 32'(taken), 1);
    cond = 4'd1;
    #1 chk("bp_ready0", 32'(req_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid_hold", 32'(resp_valid), 1);
      chk("bp_taken_hold", 32'(taken), 1);
      chk("bp_ready_low", 32'(req_ready), 0);
    end
    resp_ready = 1;
    #1 chk("bp_release_ready", 32'(req_ready), 1);
    step();
    chk("bp_next_valid", 32'(resp_valid), 1);
    chk("bp_next_taken", 32'(taken), 0);
    // reset with a pending decision and concurrent activity
    cond = 4'd0; resp_ready = 0;
    step();
    chk("pre_rst_valid", 32'(resp_valid), 1);
    rst = 1; flag_we = 1; result = 16'h8000; loop_load = 1; loop_sel = 2; loop_val = 16'd7;
    step();
    rst = 0; flag_we = 0; loop_load = 0; req_valid = 0; resp_ready = 1;
    chk("mid_rst_valid", 32'(resp_valid), 0);
    chk("mid_rst_taken", 32'(taken), 0);
    chk("mid_rst_flags", 32'(flags), 0);
    chk("mid_rst_cnt1", 32'(dut.cnt_q[1]), 0);
    chk("mid_rst_cnt2", 32'(dut.cnt_q[2]), 0);
    chk("mid_rst_ready", 32'(req_ready), 1);
    // load wins over same-cycle DJNZ
    loop_load = 1; loop_sel = 3; loop_val = 16'd1;
    step();
    loop_val = 16'd5; req_valid = 1; cond = 4'd14;
    step();
    loop_load = 0;
    chk("ld_djnz_taken", 32'(taken), 0);
    chk("ld_djnz_cnt", 32'(dut.cnt_q[3]), 5);
    step();
    chk("after_ld_taken", 32'(taken), 1);
    chk("after_ld_cnt", 32'(dut.cnt_q[3]), 4);
    req_valid = 0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
